// File: rtl/cpu_pkg.sv
// Shared CPU definitions used by the branch prediction unit.
//   bp_mode_t    : prediction strategy select
//   btb_entry_t  : one BTB slot (the per-entry counter lives in a sat_counter)
//   BP_CTR_INIT  : allocation value for a ctr_w-bit counter (weakly taken)
package cpu_pkg;

    typedef enum logic [1:0] {
        NOT_TAKEN  = 2'b00,
        TAKEN      = 2'b01,
        DELAY_SLOT = 2'b10,
        DYNAMIC    = 2'b11
    } bp_mode_t;

    // Tag is stored zero-extended to 32 bits so every depth shares one layout.
    typedef struct packed {
        logic        valid;
        logic [31:0] tag;
        logic [31:0] target;
    } btb_entry_t;

    // Weakly-taken start value: only the MSB set.
    function automatic int unsigned BP_CTR_INIT(input int unsigned ctr_w);
        return 32'd1 << (ctr_w - 1);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up/down counter with synchronous load.
//   clk, rst      : clock, synchronous active-high reset (count <= 0)
//   inc, dec      : step up / down; both together hold the value
//   load/load_val : overwrite the count (takes priority over stepping)
//   count         : current value, sticks at 0 and at all-ones
module sat_counter #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         dec,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] count
);

    localparam logic [W-1:0] MAX_VAL = '1;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (inc && !dec && count != MAX_VAL) begin
            count <= count + 1'b1;
        end else if (dec && !inc && count != '0) begin
            count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Branch prediction unit: BTB plus per-entry saturating counters.
//   mode                          : NOT_TAKEN / TAKEN / DELAY_SLOT / DYNAMIC
//   if_pc -> pred_taken/target    : same-cycle prediction for the fetch PC
//   ex_*                          : branch resolved in EX, trains the BTB
//   flush/redirect_pc             : mispredict recovery (combinational)
//   branch_count/mispredict_count : saturating performance counters
module branch_predictor
    import cpu_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int CTR_W  = 2,
    parameter int STAT_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        mode,
    input  logic [31:0]       if_pc,
    output logic              pred_taken,
    output logic [31:0]       pred_target,
    input  logic              ex_valid,
    input  logic [31:0]       ex_pc,
    input  logic              ex_taken,
    input  logic [31:0]       ex_target,
    input  logic              ex_pred_taken,
    input  logic [31:0]       ex_pred_target,
    output logic              flush,
    output logic [31:0]       redirect_pc,
    output logic [STAT_W-1:0] branch_count,
    output logic [STAT_W-1:0] mispredict_count
);

    localparam int IDX = $clog2(DEPTH);
    localparam logic [CTR_W-1:0] CTR_INIT = CTR_W'(BP_CTR_INIT(CTR_W));

    btb_entry_t       btb_reg [DEPTH];
    logic [CTR_W-1:0] ctr_val [DEPTH];

    bp_mode_t    mode_sel;
    logic [IDX-1:0] if_idx, ex_idx;
    logic [31:0] if_tag, ex_tag;
    logic        if_hit, ex_hit, if_ctr_taken, mispredict;

    assign mode_sel = bp_mode_t'(mode);
    assign if_idx   = if_pc[IDX+1:2];
    assign ex_idx   = ex_pc[IDX+1:2];
    assign if_tag   = if_pc >> (IDX + 2);
    assign ex_tag   = ex_pc >> (IDX + 2);

    // Lookups are forced to miss during reset, even before the valid bits clear.
    assign if_hit = !rst && btb_reg[if_idx].valid && (btb_reg[if_idx].tag == if_tag);
    assign ex_hit = btb_reg[ex_idx].valid && (btb_reg[ex_idx].tag == ex_tag);

    // Comparing against the weakly-taken value is the same as testing the MSB.
    assign if_ctr_taken = (ctr_val[if_idx] >= CTR_INIT);

    always_comb begin
        pred_taken = 1'b0;
        case (mode_sel)
            TAKEN:   pred_taken = if_hit;
            DYNAMIC: pred_taken = if_hit && if_ctr_taken;
            default: pred_taken = 1'b0;
        endcase
    end

    assign pred_target = pred_taken ? btb_reg[if_idx].target : if_pc + 32'd4;

    assign mispredict = ex_valid &&
                        ((ex_taken != ex_pred_taken) ||
                         (ex_taken && (ex_target != ex_pred_target)));
    assign flush = mispredict;

    // In delay-slot mode the slot instruction survives, so fall-through skips it.
    always_comb begin
        if (ex_taken) begin
            redirect_pc = ex_target;
        end else if (mode_sel == DELAY_SLOT) begin
            redirect_pc = ex_pc + 32'd8;
        end else begin
            redirect_pc = ex_pc + 32'd4;
        end
    end

    // A taken resolve always writes the indexed slot: on a hit it refreshes
    // the target, on a miss it allocates over whatever was there.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                btb_reg[i].valid <= 1'b0;
            end
        end else if (ex_valid && ex_taken) begin
            btb_reg[ex_idx] <= '{valid: 1'b1, tag: ex_tag, target: ex_target};
        end
    end

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_ctr
            logic sel;
            assign sel = ex_valid && (ex_idx == IDX'(gi));

            sat_counter #(.W(CTR_W)) u_ctr (
                .clk      (clk),
                .rst      (rst),
                .inc      (sel && ex_hit && ex_taken),
                .dec      (sel && ex_hit && !ex_taken),
                .load     (sel && !ex_hit && ex_taken),
                .load_val (CTR_INIT),
                .count    (ctr_val[gi])
            );
        end
    endgenerate

    sat_counter #(.W(STAT_W)) u_branch_count (
        .clk      (clk),
        .rst      (rst),
        .inc      (ex_valid),
        .dec      (1'b0),
        .load     (1'b0),
        .load_val ('0),
        .count    (branch_count)
    );

    sat_counter #(.W(STAT_W)) u_mispredict_count (
        .clk      (clk),
        .rst      (rst),
        .inc      (mispredict),
        .dec      (1'b0),
        .load     (1'b0),
        .load_val ('0),
        .count    (mispredict_count)
    );

endmodule

// File: tb/tb_branch_predictor.sv
module tb_branch_predictor;
    import cpu_pkg::*;

    logic        clk, rst;
    logic [1:0]  mode;
    logic [31:0] if_pc, ex_pc, ex_target, ex_pred_target;
    logic        ex_valid, ex_taken, ex_pred_taken;

    logic        pred_taken, flush;
    logic [31:0] pred_target, redirect_pc, branch_count, mispredict_count;

    logic        s_pred_taken, s_flush;
    logic [31:0] s_pred_target, s_redirect_pc;
    logic [3:0]  s_bc, s_mc;

    int total = 0;
    int bad   = 0;

    branch_predictor #(.DEPTH(16), .CTR_W(2), .STAT_W(32)) dut (
        .clk(clk), .rst(rst), .mode(mode), .if_pc(if_pc),
        .pred_taken(pred_taken), .pred_target(pred_target),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_taken(ex_taken),
        .ex_target(ex_target), .ex_pred_taken(ex_pred_taken),
        .ex_pred_target(ex_pred_target), .flush(flush),
        .redirect_pc(redirect_pc), .branch_count(branch_count),
        .mispredict_count(mispredict_count)
    );

    // Small corner configuration: 2 entries, 1-bit counters, 4-bit stats.
    branch_predictor #(.DEPTH(2), .CTR_W(1), .STAT_W(4)) dut_small (
        .clk(clk), .rst(rst), .mode(mode), .if_pc(if_pc),
        .pred_taken(s_pred_taken), .pred_target(s_pred_target),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_taken(ex_taken),
        .ex_target(ex_target), .ex_pred_taken(ex_pred_taken),
        .ex_pred_target(ex_pred_target), .flush(s_flush),
        .redirect_pc(s_redirect_pc), .branch_count(s_bc),
        .mispredict_count(s_mc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  m;
        logic [31:0] ipc;
        logic        v;
        logic [31:0] epc;
        logic        et;
        logic [31:0] etgt;
        logic        ept;
        logic [31:0] eptgt;
        logic        x_taken;
        logic [31:0] x_target;
        logic        x_flush;
        logic [31:0] x_redirect;
    } vec_t;

    vec_t vecs[24];

    function automatic vec_t mkv(input logic [1:0] m, input logic [31:0] ipc,
                                 input logic v, input logic [31:0] epc,
                                 input logic et, input logic [31:0] etgt,
                                 input logic ept, input logic [31:0] eptgt,
                                 input logic xt, input logic [31:0] xtgt,
                                 input logic xf, input logic [31:0] xr);
        vec_t r;
        r.m = m; r.ipc = ipc; r.v = v; r.epc = epc; r.et = et; r.etgt = etgt;
        r.ept = ept; r.eptgt = eptgt; r.x_taken = xt; r.x_target = xtgt;
        r.x_flush = xf; r.x_redirect = xr;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [1:0] m, input logic [31:0] ipc, input logic v,
                         input logic [31:0] epc, input logic et, input logic [31:0] etgt,
                         input logic ept, input logic [31:0] eptgt);
        mode = m; if_pc = ipc; ex_valid = v; ex_pc = epc; ex_taken = et;
        ex_target = etgt; ex_pred_taken = ept; ex_pred_target = eptgt;
    endtask

    task automatic idle(input logic [1:0] m, input logic [31:0] ipc);
        drive(m, ipc, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    localparam logic [1:0] MN = 2'(NOT_TAKEN);
    localparam logic [1:0] MT = 2'(TAKEN);
    localparam logic [1:0] MS = 2'(DELAY_SLOT);
    localparam logic [1:0] MD = 2'(DYNAMIC);

    initial begin
        //                m   if_pc        v  ex_pc    et etgt      ept eptgt     | pt tgt         fl redirect
        vecs[0]  = mkv(MD, 32'h1C, 1, 32'h1C, 1, 32'h0C,  0, 32'h0,   0, 32'h20,  1, 32'h0C);
        vecs[1]  = mkv(MD, 32'h1C, 0, 32'h0,  0, 32'h0,   0, 32'h0,   1, 32'h0C,  0, 32'h04);
        vecs[2]  = mkv(MD, 32'h1C, 1, 32'h1C, 0, 32'h0,   1, 32'h0C,  1, 32'h0C,  1, 32'h20);
        vecs[3]  = mkv(MD, 32'h1C, 1, 32'h1C, 0, 32'h0,   0, 32'h0,   0, 32'h20,  0, 32'h20);
        vecs[4]  = mkv(MD, 32'h1C, 0, 32'h0,  0, 32'h0,   0, 32'h0,   0, 32'h20,  0, 32'h04);
        vecs[5]  = mkv(MD, 32'h24, 1, 32'h24, 1, 32'h100, 0, 32'h0,   0, 32'h28,  1, 32'h100);
        vecs[6]  = mkv(MD, 32'h24, 1, 32'h24, 1, 32'h100, 1, 32'h100, 1, 32'h100, 0, 32'h100);
        vecs[7]  = vecs[6];
        vecs[8]  = vecs[6];
        vecs[9]  = vecs[6];
        vecs[10] = mkv(MD, 32'h24, 1, 32'h24, 0, 32'h0,   1, 32'h100, 1, 32'h100, 1, 32'h28);
        vecs[11] = mkv(MD, 32'h24, 0, 32'h0,  0, 32'h0,   0, 32'h0,   1, 32'h100, 0, 32'h04);
        vecs[12] = mkv(MD, 32'h24, 1, 32'h24, 1, 32'h200, 1, 32'h100, 1, 32'h100, 1, 32'h200);
        vecs[13] = mkv(MD, 32'h24, 0, 32'h0,  0, 32'h0,   0, 32'h0,   1, 32'h200, 0, 32'h04);
        vecs[14] = mkv(MD, 32'h10, 1, 32'h10, 1, 32'h80,  0, 32'h0,   0, 32'h14,  1, 32'h80);
        vecs[15] = mkv(MD, 32'h10, 1, 32'h50, 1, 32'h90,  0, 32'h0,   1, 32'h80,  1, 32'h90);
        vecs[16] = mkv(MD, 32'h10, 0, 32'h0,  0, 32'h0,   0, 32'h0,   0, 32'h14,  0, 32'h04);
        vecs[17] = mkv(MD, 32'h50, 0, 32'h0,  0, 32'h0,   0, 32'h0,   1, 32'h90,  0, 32'h04);
        vecs[18] = mkv(MN, 32'h50, 0, 32'h0,  0, 32'h0,   0, 32'h0,   0, 32'h54,  0, 32'h04);
        vecs[19] = mkv(MT, 32'h1C, 0, 32'h0,  0, 32'h0,   0, 32'h0,   1, 32'h0C,  0, 32'h04);
        vecs[20] = mkv(MS, 32'h50, 1, 32'h10, 0, 32'h0,   0, 32'h0,   0, 32'h54,  0, 32'h18);
        vecs[21] = mkv(MS, 32'h50, 1, 32'h10, 0, 32'h0,   1, 32'h80,  0, 32'h54,  1, 32'h18);
        vecs[22] = mkv(MD, 32'h50, 0, 32'h0,  0, 32'h0,   0, 32'h0,   1, 32'h90,  0, 32'h04);
        vecs[23] = mkv(MD, 32'hFFFFFFFC, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0, 32'h0,  0, 32'h04);

        // Reset
        rst = 1'b1;
        idle(MD, 32'h40);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset_pred_taken", 32'(pred_taken), 32'd0);
        chk("reset_pred_target", pred_target, 32'h44);
        chk("reset_branch_count", branch_count, 32'd0);
        chk("reset_mispredict_count", mispredict_count, 32'd0);

        // Every index misses after reset
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            idle(MD, 32'(i * 4));
            #1;
            chk("reset_entry_miss", 32'(pred_taken), 32'd0);
            chk("reset_entry_target", pred_target, 32'(i * 4 + 4));
        end

        // Vector table
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            drive(vecs[i].m, vecs[i].ipc, vecs[i].v, vecs[i].epc, vecs[i].et,
                  vecs[i].etgt, vecs[i].ept, vecs[i].eptgt);
            #1;
            $display("vec %0d: if_pc=%08h pred=%0d/%08h flush=%0d redirect=%08h",
                     i, if_pc, pred_taken, pred_target, flush, redirect_pc);
            chk("vec_pred_taken", 32'(pred_taken), 32'(vecs[i].x_taken));
            chk("vec_pred_target", pred_target, vecs[i].x_target);
            chk("vec_flush", 32'(flush), 32'(vecs[i].x_flush));
            chk("vec_redirect", redirect_pc, vecs[i].x_redirect);
            chk("vec_small_flush", 32'(s_flush), 32'(vecs[i].x_flush));
            chk("vec_small_redirect", s_redirect_pc, vecs[i].x_redirect);
        end

        @(negedge clk);
        idle(MD, 32'h0);
        #1;
        chk("table_branch_count", branch_count, 32'd14);
        chk("table_mispredict_count", mispredict_count, 32'd8);
        chk("table_small_branch_count", 32'(s_bc), 32'd14);
        chk("table_small_mispredict_count", 32'(s_mc), 32'd8);

        // Reset with an update pending: lookup gated, flush still live, update dropped
        @(negedge clk);
        rst = 1'b1;
        drive(MD, 32'h24, 1'b1, 32'h30, 1'b1, 32'h40, 1'b0, 32'h0);
        #1;
        chk("rst_pred_taken", 32'(pred_taken), 32'd0);
        chk("rst_pred_target", pred_target, 32'h28);
        chk("rst_flush", 32'(flush), 32'd1);
        chk("rst_redirect", redirect_pc, 32'h40);
        @(negedge clk);
        rst = 1'b0;
        idle(MD, 32'h30);
        #1;
        chk("rst_dropped_update", 32'(pred_taken), 32'd0);
        chk("rst_dropped_target", pred_target, 32'h34);
        chk("rst_branch_count", branch_count, 32'd0);
        chk("rst_mispredict_count", mispredict_count, 32'd0);
        chk("rst_small_branch_count", 32'(s_bc), 32'd0);
        @(negedge clk);
        idle(MD, 32'h24);
        #1;
        chk("rst_cleared_entry", 32'(pred_taken), 32'd0);

        // 10 branches, first 3 mispredicted
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            drive(MD, 32'h0, 1'b1, 32'h8, 1'b1, 32'h100, (i >= 3), 32'h100);
            $display("stat branch %0d: pred_taken_in=%0d", i, ex_pred_taken);
        end
        @(negedge clk);
        idle(MD, 32'h8);
        #1;
        chk("stats_branch_count", branch_count, 32'd10);
        chk("stats_mispredict_count", mispredict_count, 32'd3);
        chk("small_branch_count_10", 32'(s_bc), 32'd10);
        chk("small_mispredict_count_3", 32'(s_mc), 32'd3);
        chk("seq_pred_taken", 32'(pred_taken), 32'd1);
        chk("seq_pred_target", pred_target, 32'h100);
        chk("small_pred_taken", 32'(s_pred_taken), 32'd1);
        chk("small_pred_target", s_pred_target, 32'h100);

        // 10 more, all correctly predicted: 4-bit stats stick at 15
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            drive(MD, 32'h0, 1'b1, 32'h8, 1'b1, 32'h100, 1'b1, 32'h100);
            $display("stat branch %0d: pred_taken_in=%0d", i + 10, ex_pred_taken);
        end
        @(negedge clk);
        idle(MD, 32'h8);
        #1;
        chk("stats_branch_count_20", branch_count, 32'd20);
        chk("stats_mispredict_count_20", mispredict_count, 32'd3);
        chk("small_branch_count_sat", 32'(s_bc), 32'd15);
        chk("small_mispredict_count_20", 32'(s_mc), 32'd3);

        // One not-taken: 1-bit counter drops to 0, 2-bit counter drops to 2
        @(negedge clk);
        drive(MD, 32'h8, 1'b1, 32'h8, 1'b0, 32'h0, 1'b0, 32'h0);
        #1;
        chk("nt_flush", 32'(flush), 32'd0);
        chk("nt_redirect", redirect_pc, 32'h0C);
        @(negedge clk);
        idle(MD, 32'h8);
        #1;
        chk("nt_pred_taken", 32'(pred_taken), 32'd1);
        chk("nt_pred_target", pred_target, 32'h100);
        chk("nt_small_pred_taken", 32'(s_pred_taken), 32'd0);
        chk("nt_small_pred_target", s_pred_target, 32'h0C);
        chk("nt_branch_count", branch_count, 32'd21);
        chk("nt_small_branch_count", 32'(s_bc), 32'd15);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/branch_predictor.md
# branch_predictor

Parametrised branch prediction unit for the five-stage pipelined CPU, replacing the fixed 2-bit strategy select with a configurable BTB plus saturating-counter predictor. It supplies a next-PC prediction to the IF stage in the same cycle. It also resolves branches reported by the EX stage, raises flush/redirect on mispredict, and keeps saturating performance counters. Modes cover static not-taken, static taken, delay-slot, and dynamic prediction.

## Interface
- `DEPTH`, 16: BTB entries; power of two, ≥2.
- `CTR_W`, 2: saturating counter width; 1..4.
- `STAT_W`, 32: width of performance counters.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `mode` in 2: 00 NOT_TAKEN, 01 TAKEN, 10 DELAY_SLOT, 11 DYNAMIC.
- `if_pc` in 32: PC being fetched.
- `pred_taken` out 1: prediction for `if_pc`.
- `pred_target` out 32: predicted next PC; equals `if_pc+4` when not taken.
- `ex_valid` in 1: a resolved branch or jump is in EX this cycle.
- `ex_pc` in 32: PC of the resolved instruction.
- `ex_taken` in 1: actual outcome.
- `ex_target` in 32: actual taken target.
- `ex_pred_taken` in 1: prediction carried down the pipeline with the instruction.
- `ex_pred_target` in 32: predicted target carried down the pipeline with the instruction.
- `flush` out 1: squash younger wrong-path instructions.
- `redirect_pc` out 32: PC to load when `flush`=1.
- `branch_count` out STAT_W: resolved branches.
- `mispredict_count` out STAT_W: mispredicts.

## Operation
- BTB entry fields:
  - valid
  - tag = pc[31:IDX+2]
  - target
  - CTR_W-bit counter
- Index = pc[IDX+1:2], where IDX = log2(DEPTH).
- BTB hit: entry valid and tag equal.
- Lookup is combinational on `if_pc`.
- Prediction by mode:
  - NOT_TAKEN: `pred_taken`=0.
  - DELAY_SLOT: `pred_taken`=0.
  - TAKEN: `pred_taken`=hit.
  - DYNAMIC: `pred_taken`=hit && counter MSB=1.
- `pred_target` = hit entry target if `pred_taken`, else `if_pc+4` (32-bit wrap).
- Mispredict = `ex_valid` && (`ex_taken`≠`ex_pred_taken` || (`ex_taken` && `ex_target`≠`ex_pred_target`)).
- `flush` = mispredict, combinational.
- `redirect_pc`:
  - `ex_taken` → `ex_target`.
  - Otherwise `ex_pc+4`.
  - In DELAY_SLOT mode, not-taken redirect is `ex_pc+8`.
  - In DELAY_SLOT mode the pipeline preserves the slot instruction; this block only supplies the PC.
- Update on `ex_valid` at the clock edge, in all modes:
  - Hit: write target ← `ex_target` if taken; counter +1 if taken, −1 if not, saturating at 0 and 2^CTR_W−1.
  - Miss and taken: allocate (overwrite) the indexed entry: valid=1, tag, target, counter = 2^(CTR_W−1) (weakly taken).
  - Miss and not taken: no allocation.
- Stats:
  - `branch_count` +1 per `ex_valid`.
  - `mispredict_count` +1 per mispredict.
  - Both saturate at all-ones.
- Changing `mode` takes effect combinationally. The BTB is never cleared by a mode change.

## Timing
- Reset (sync, `rst`=1 at the edge):
  - All valid bits ← 0.
  - Counters ← 0; both stats ← 0.
  - Targets and tags are don't-care.
  - Reset mid-update: reset wins, and the update is dropped.
- While `rst`=1:
  - Lookups miss, so `pred_taken`=0 and `pred_target`=`if_pc+4`.
  - `flush` still follows its combinational equation; the pipeline ignores it during reset.
- Lookup latency 0 cycles. Update visible to lookup from the cycle after the edge.
- Same-cycle read and write to one index: the lookup sees the old contents (no bypass).
- Both stats counters increment in the same edge on a mispredicting branch.
- DEPTH=2 or a 1-bit counter must behave per the same rules. With CTR_W=1 the allocation value is 1.

## Structure
- Shared package `cpu_pkg` holds:
  - enum `bp_mode_t` (NOT_TAKEN=2'b00, TAKEN=2'b01, DELAY_SLOT=2'b10, DYNAMIC=2'b11)
  - `BP_CTR_INIT` function
  - struct `btb_entry_t`
- Sub-module `sat_counter`: parametrised saturating up/down counter. It is used for the per-entry counters and, at STAT_W with up only, for the stats.
- The BTB is a register array, not memory macros, so reset can clear the valid bits in one cycle.

## Test plan
- Reset → all 16 entries invalid; `if_pc`=0x40 gives `pred_taken`=0, `pred_target`=0x44; both stats 0.
- DYNAMIC, DEPTH=16: resolve `ex_pc`=0x1C taken to 0x0C once (predicted 0) → `flush`=1, `redirect_pc`=0x0C; next cycle `if_pc`=0x1C predicts taken/0x0C. Two not-taken resolves → counter 0; `pred_taken`=0.
- Saturation at CTR_W=2: five taken resolves of one PC → counter 3; one not-taken → still predicts taken.
- Aliasing: allocate 0x10, then taken 0x50 (same index, different tag) → lookup of 0x10 misses; 0x50 hits.
- DELAY_SLOT: `ex_pc`=0x10, `ex_taken`=0, `ex_pred_taken`=0 → no flush. Predicted-taken-but-not-taken case → `redirect_pc`=0x18.
- Stats: 10 branches with 3 mispredicts → 10 / 3. At STAT_W=4, 20 branches → `branch_count` holds 15. Same-cycle write/read of one index returns the old entry.
